// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-requester SRAM port arbiter.
// Holds the owner encoding, default widths and the hold-count ceiling.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_t;

  localparam int ADDR_W_DFLT    = 4;
  localparam int DATA_W_DFLT    = 512;
  localparam int BE_W_DFLT      = 64;
  localparam int MAX_HOLD_LIMIT = 15;

endpackage

// File: rtl/sram_arb_rr_core.sv
// Round-robin grant with bounded burst hold; purely combinational.
// In: req_a/req_b + owner/hold_cnt/rr_last. Out: grants + next state.
module sram_arb_rr_core
  import sram_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       req_a,
  input  logic       req_b,
  input  owner_t     owner,
  input  logic [3:0] hold_cnt,
  input  owner_t     rr_last,
  output logic       grant_a,
  output logic       grant_b,
  output owner_t     owner_nxt,
  output logic [3:0] hold_nxt,
  output owner_t     rr_nxt
);

  logic       under;
  logic [3:0] hold_inc;

  assign under = hold_cnt < 4'(MAX_HOLD);

  // Hold count sticks at its ceiling so a long solo burst never wraps.
  assign hold_inc = (hold_cnt == 4'(MAX_HOLD_LIMIT)) ?
                    hold_cnt : hold_cnt + 4'd1;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (owner)
      OWN_A: begin
        if (req_a && (under || !req_b)) grant_a = 1'b1;
        else if (req_b)                 grant_b = 1'b1;
      end
      OWN_B: begin
        if (req_b && (under || !req_a)) grant_b = 1'b1;
        else if (req_a)                 grant_a = 1'b1;
      end
      default: begin
        if (req_a && req_b) begin
          grant_a = (rr_last != OWN_A);
          grant_b = (rr_last == OWN_A);
        end else begin
          grant_a = req_a;
          grant_b = req_b;
        end
      end
    endcase
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    hold_nxt  = '0;
    rr_nxt    = rr_last;
    unique case (1'b1)
      grant_a: begin
        owner_nxt = OWN_A;
        rr_nxt    = OWN_A;
        hold_nxt  = (owner == OWN_A) ? hold_inc : 4'd1;
      end
      grant_b: begin
        owner_nxt = OWN_B;
        rr_nxt    = OWN_B;
        hold_nxt  = (owner == OWN_B) ? hold_inc : 4'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between Avalon-MM requesters A and B.
// Ports: a_*/b_* slave sides, sram_* master side, clk, reset_n.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DFLT,
  parameter int DATA_W   = DATA_W_DFLT,
  parameter int BE_W     = BE_W_DFLT,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  input  logic [BE_W-1:0]   a_byteenable,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  input  logic [BE_W-1:0]   b_byteenable,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  output logic [BE_W-1:0]   sram_byteenable,
  output logic              sram_clken,
  input  logic [DATA_W-1:0] sram_readdata
);

  owner_t     owner_q;
  owner_t     owner_nxt;
  owner_t     rr_q;
  owner_t     rr_nxt;
  owner_t     rd_owner_q;
  logic [3:0] hold_q;
  logic [3:0] hold_nxt;
  logic       rd_pend_q;
  logic       req_a;
  logic       req_b;
  logic       grant_a;
  logic       grant_b;
  logic       rd_acc;

  // Requests are masked in reset so nothing is granted or accepted.
  assign req_a = reset_n & (a_read | a_write);
  assign req_b = reset_n & (b_read | b_write);

  sram_arb_rr_core #(
    .MAX_HOLD (MAX_HOLD)
  ) u_core (
    .req_a     (req_a),
    .req_b     (req_b),
    .owner     (owner_q),
    .hold_cnt  (hold_q),
    .rr_last   (rr_q),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .owner_nxt (owner_nxt),
    .hold_nxt  (hold_nxt),
    .rr_nxt    (rr_nxt)
  );

  assign a_waitrequest = ~reset_n | (req_a & ~grant_a);
  assign b_waitrequest = ~reset_n | (req_b & ~grant_b);

  assign sram_clken = 1'b1;

  always_comb begin
    sram_chipselect = grant_a | grant_b;
    sram_address    = '0;
    sram_write      = 1'b0;
    sram_writedata  = '0;
    sram_byteenable = '0;
    rd_acc          = 1'b0;
    unique case (1'b1)
      grant_a: begin
        sram_address    = a_address;
        sram_write      = a_write;
        sram_writedata  = a_writedata;
        sram_byteenable = a_byteenable;
        rd_acc          = a_read & ~a_write;
      end
      grant_b: begin
        sram_address    = b_address;
        sram_write      = b_write;
        sram_writedata  = b_writedata;
        sram_byteenable = b_byteenable;
        rd_acc          = b_read & ~b_write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q    <= OWN_NONE;
      hold_q     <= '0;
      rr_q       <= OWN_B;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_NONE;
    end else begin
      owner_q    <= owner_nxt;
      hold_q     <= hold_nxt;
      rr_q       <= rr_nxt;
      rd_pend_q  <= rd_acc;
      rd_owner_q <= grant_b ? OWN_B : OWN_A;
    end
  end

  // A return still in flight when reset asserts is dropped.
  assign a_readdatavalid = reset_n & rd_pend_q &
                           (rd_owner_q == OWN_A);
  assign b_readdatavalid = reset_n & rd_pend_q &
                           (rd_owner_q == OWN_B);

  assign a_readdata = sram_readdata;
  assign b_readdata = sram_readdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic
// against a transaction-level model of grants, memory and returns.
module tb_sram_port_arbiter;

  localparam int AW = 4;
  localparam int DW = 512;
  localparam int BW = 64;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] a_address, b_address;
  logic          a_read, a_write, b_read, b_write;
  logic [DW-1:0] a_writedata, b_writedata;
  logic [BW-1:0] a_byteenable, b_byteenable;
  logic          a_waitrequest, b_waitrequest;
  logic [DW-1:0] a_readdata, b_readdata;
  logic          a_readdatavalid, b_readdatavalid;
  logic [AW-1:0] sram_address;
  logic          sram_chipselect, sram_write, sram_clken;
  logic [DW-1:0] sram_writedata, sram_readdata;
  logic [BW-1:0] sram_byteenable;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .a_address(a_address), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_byteenable(a_byteenable),
    .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_byteenable(b_byteenable),
    .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .sram_address(sram_address), .sram_chipselect(sram_chipselect),
    .sram_write(sram_write), .sram_writedata(sram_writedata),
    .sram_byteenable(sram_byteenable), .sram_clken(sram_clken),
    .sram_readdata(sram_readdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    logic [3:0] n;
    n = i[3:0];
    return {16{28'hC0FFEE0, n}};
  endfunction

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // SRAM: registered address, unregistered data out.
  logic          preload;
  logic [DW-1:0] mem [16];
  logic [AW-1:0] rd_addr_q;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      rd_addr_q <= '0;
    end else if (sram_chipselect && sram_clken) begin
      if (sram_write)
        for (int i = 0; i < BW; i++)
          if (sram_byteenable[i])
            mem[sram_address][8*i +: 8] <= sram_writedata[8*i +: 8];
      rd_addr_q <= sram_address;
    end
  end

  assign sram_readdata = mem[rd_addr_q];

  // Model: 0 = nobody, 1 = A, 2 = B.
  int            m_owner, m_streak, m_last, m_pend_own;
  bit            m_pend;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] m_mem [16];

  task automatic m_reset();
    m_owner  = 0;
    m_streak = 0;
    m_last   = 2;
    m_pend   = 0;
  endtask

  function automatic int m_grant(input bit ra, input bit rb);
    bit own, oth;
    if (m_owner != 0) begin
      own = (m_owner == 1) ? ra : rb;
      oth = (m_owner == 1) ? rb : ra;
      if (own && (m_streak < MH || !oth)) return m_owner;
      if (oth) return 3 - m_owner;
      return 0;
    end
    if (ra && rb) return 3 - m_last;
    if (ra) return 1;
    if (rb) return 2;
    return 0;
  endfunction

  task automatic m_commit(input int g, input bit rd,
                          input logic [AW-1:0] addr, input bit wr,
                          input logic [DW-1:0] wd,
                          input logic [BW-1:0] be);
    m_pend     = (g != 0) && rd && !wr;
    m_pend_own = g;
    if (m_pend) m_pend_data = m_mem[addr];
    if (g != 0 && wr)
      for (int i = 0; i < BW; i++)
        if (be[i]) m_mem[addr][8*i +: 8] = wd[8*i +: 8];
    if (g == 0) begin
      m_owner  = 0;
      m_streak = 0;
    end else begin
      m_streak = (g == m_owner) ? m_streak + 1 : 1;
      m_owner  = g;
      m_last   = g;
    end
  endtask

  task automatic idle();
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    a_address = '0; b_address = '0;
    a_writedata = '0; b_writedata = '0;
    a_byteenable = '0; b_byteenable = '0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    m_reset();
  endtask

  task automatic test_reset();
    reset_n = 0;
    a_read = 1; b_write = 1; b_byteenable = '1;
    #3;
    n_tests++;
    if ({a_waitrequest, b_waitrequest, sram_chipselect,
         a_readdatavalid, b_readdatavalid} !== 5'b11000) begin
      n_fail++;
      $display("FAIL rst_hold: got %b want 11000",
        {a_waitrequest, b_waitrequest, sram_chipselect,
         a_readdatavalid, b_readdatavalid});
    end
    @(posedge clk); #1;
    reset_n = 1; m_reset(); idle();
    #3;
    n_tests++;
    if (sram_clken !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_clken: got %b want 1", sram_clken);
    end
    n_tests++;
    if ({a_waitrequest, b_waitrequest, sram_chipselect} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_idle: got %b want 000",
        {a_waitrequest, b_waitrequest, sram_chipselect});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] pat;
    pat = {64{8'hA5}};
    do_reset();
    a_write = 1; a_address = 3; a_writedata = pat; a_byteenable = '1;
    #3;
    n_tests++;
    if ({a_waitrequest, sram_chipselect, sram_write} !== 3'b011) begin
      n_fail++;
      $display("FAIL wr_accept: got %b want 011",
        {a_waitrequest, sram_chipselect, sram_write});
    end
    m_commit(1, 0, 4'd3, 1, pat, '1);
    @(posedge clk); #1;
    a_write = 0; a_read = 1;
    #3;
    n_tests++;
    if ({a_waitrequest, a_readdatavalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_accept: got %b want 00",
        {a_waitrequest, a_readdatavalid});
    end
    @(posedge clk); #1;
    idle();
    #3;
    n_tests++;
    if ({a_readdatavalid, b_readdatavalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rd_valid: got %b want 10",
        {a_readdatavalid, b_readdatavalid});
    end
    n_tests++;
    if (a_readdata !== pat) begin
      n_fail++;
      $display("FAIL rd_data: got %h want %h", a_readdata, pat);
    end
    @(posedge clk); #1;
    #3;
    n_tests++;
    if (a_readdatavalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_once: got %b want 0", a_readdatavalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    bit exp_a, prev_a;
    do_reset();
    a_read = 1; a_address = 4;
    b_read = 1; b_address = 6;
    prev_a = 0;
    for (int i = 0; i < 16; i++) begin
      exp_a = ((i / 4) % 2) == 0;
      #3;
      n_tests++;
      if ({a_waitrequest, b_waitrequest} !== {!exp_a, exp_a}) begin
        n_fail++;
        $display("FAIL hold_grant[%0d]: got %b want %b", i,
          {a_waitrequest, b_waitrequest}, {!exp_a, exp_a});
      end
      if (i > 0) begin
        n_tests++;
        if ({a_readdatavalid, b_readdatavalid} !== {prev_a, !prev_a}) begin
          n_fail++;
          $display("FAIL hold_rdv[%0d]: got %b want %b", i,
            {a_readdatavalid, b_readdatavalid}, {prev_a, !prev_a});
        end
      end
      prev_a = exp_a;
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    a_read = 1; a_address = 2;
    for (int i = 0; i < 10; i++) begin
      #3;
      n_tests++;
      if ({a_waitrequest, sram_chipselect} !== 2'b01) begin
        n_fail++;
        $display("FAIL solo[%0d]: got %b want 01", i,
          {a_waitrequest, sram_chipselect});
      end
      @(posedge clk); #1;
    end
    b_read = 1; b_address = 7;
    #3;
    n_tests++;
    if ({a_waitrequest, b_waitrequest} !== 2'b10) begin
      n_fail++;
      $display("FAIL solo_switch: got %b want 10",
        {a_waitrequest, b_waitrequest});
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_tie();
    do_reset();
    a_read = 1; a_address = 1;
    b_read = 1; b_address = 2;
    #3;
    n_tests++;
    if ({a_waitrequest, b_waitrequest} !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_first: got %b want 01",
        {a_waitrequest, b_waitrequest});
    end
    @(posedge clk); #1;
    a_read = 0;
    #3;
    n_tests++;
    if ({a_waitrequest, b_waitrequest,
         a_readdatavalid, b_readdatavalid} !== 4'b0010) begin
      n_fail++;
      $display("FAIL tie_second: got %b want 0010",
        {a_waitrequest, b_waitrequest,
         a_readdatavalid, b_readdatavalid});
    end
    n_tests++;
    if (a_readdata !== m_mem[1]) begin
      n_fail++;
      $display("FAIL tie_a_data: got %h want %h", a_readdata, m_mem[1]);
    end
    @(posedge clk); #1;
    idle();
    #3;
    n_tests++;
    if ({a_readdatavalid, b_readdatavalid} !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_b_rdv: got %b want 01",
        {a_readdatavalid, b_readdatavalid});
    end
    n_tests++;
    if (b_readdata !== m_mem[2]) begin
      n_fail++;
      $display("FAIL tie_b_data: got %h want %h", b_readdata, m_mem[2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byteenable();
    logic [DW-1:0] k, d, exp15;
    k = rand512();
    d = rand512();
    exp15 = {k[DW-1:8], d[7:0]};
    do_reset();
    b_write = 1; b_address = 15; b_writedata = k; b_byteenable = '1;
    #3;
    n_tests++;
    if (b_waitrequest !== 1'b0) begin
      n_fail++;
      $display("FAIL be_wr_full: got %b want 0", b_waitrequest);
    end
    m_commit(2, 0, 4'd15, 1, k, '1);
    @(posedge clk); #1;
    b_writedata = d; b_byteenable = 64'h1;
    #3;
    n_tests++;
    if (sram_byteenable !== 64'h1) begin
      n_fail++;
      $display("FAIL be_pass: got %h want 1", sram_byteenable);
    end
    m_commit(2, 0, 4'd15, 1, d, 64'h1);
    @(posedge clk); #1;
    b_address = 0; b_byteenable = '0;
    #3;
    n_tests++;
    if ({sram_write, sram_byteenable} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL be_zero: got %b/%h want 1/0",
        sram_write, sram_byteenable);
    end
    m_commit(2, 0, 4'd0, 1, d, '0);
    @(posedge clk); #1;
    b_write = 0; b_read = 1; b_address = 15;
    @(posedge clk); #1;
    b_address = 0;
    #3;
    n_tests++;
    if (b_readdatavalid !== 1'b1 || b_readdata !== exp15) begin
      n_fail++;
      $display("FAIL be_byte0: got %b/%h want 1/%h",
        b_readdatavalid, b_readdata, exp15);
    end
    @(posedge clk); #1;
    idle();
    #3;
    n_tests++;
    if (b_readdatavalid !== 1'b1 || b_readdata !== m_mem[0]) begin
      n_fail++;
      $display("FAIL be_wrap0: got %b/%h want 1/%h",
        b_readdatavalid, b_readdata, m_mem[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midburst();
    do_reset();
    a_read = 1; a_address = 5;
    #3;
    n_tests++;
    if (a_waitrequest !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_accept: got %b want 0", a_waitrequest);
    end
    @(posedge clk); #1;
    reset_n = 0; b_read = 1; b_address = 9;
    #3;
    n_tests++;
    if ({a_waitrequest, b_waitrequest, sram_chipselect,
         a_readdatavalid, b_readdatavalid} !== 5'b11000) begin
      n_fail++;
      $display("FAIL mid_in_rst: got %b want 11000",
        {a_waitrequest, b_waitrequest, sram_chipselect,
         a_readdatavalid, b_readdatavalid});
    end
    @(posedge clk); #1;
    reset_n = 1;
    m_reset();
    #3;
    n_tests++;
    if ({a_waitrequest, b_waitrequest, a_readdatavalid} !== 3'b010) begin
      n_fail++;
      $display("FAIL mid_post_tie: got %b want 010",
        {a_waitrequest, b_waitrequest, a_readdatavalid});
    end
    @(posedge clk); #1;
    a_read = 0;
    #3;
    n_tests++;
    if ({b_waitrequest, a_readdatavalid} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_post_rd: got %b want 01",
        {b_waitrequest, a_readdatavalid});
    end
    @(posedge clk); #1;
    idle();
  endtask

  function automatic logic [BW-1:0] rand_be();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return {$urandom, $urandom};
  endfunction

  task automatic test_random();
    int            g;
    bit            ra, rb;
    logic [5:0]    exp_ctl;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] got_data;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      ra = $urandom_range(0, 9) < 6;
      rb = $urandom_range(0, 9) < 6;
      a_write = ra && ($urandom_range(0, 2) == 0);
      a_read  = ra && (!a_write || ($urandom_range(0, 3) == 0));
      b_write = rb && ($urandom_range(0, 2) == 0);
      b_read  = rb && (!b_write || ($urandom_range(0, 3) == 0));
      a_address = 4'($urandom_range(0, 15));
      b_address = 4'($urandom_range(0, 15));
      a_writedata = rand512();
      b_writedata = rand512();
      a_byteenable = rand_be();
      b_byteenable = rand_be();
      reset_n = ($urandom_range(0, 49) != 0);
      g = reset_n ? m_grant(ra, rb) : 0;
      exp_ctl = {
        !reset_n || (ra && g != 1),
        !reset_n || (rb && g != 2),
        g != 0,
        (g == 1 && a_write) || (g == 2 && b_write),
        reset_n && m_pend && m_pend_own == 1,
        reset_n && m_pend && m_pend_own == 2
      };
      exp_addr = (g == 1) ? a_address : (g == 2) ? b_address : '0;
      #3;
      n_tests++;
      if ({a_waitrequest, b_waitrequest, sram_chipselect, sram_write,
           a_readdatavalid, b_readdatavalid} !== exp_ctl) begin
        n_fail++;
        $display("FAIL rnd_ctl[%0d]: got %b want %b", c,
          {a_waitrequest, b_waitrequest, sram_chipselect, sram_write,
           a_readdatavalid, b_readdatavalid}, exp_ctl);
      end
      n_tests++;
      if (sram_address !== exp_addr) begin
        n_fail++;
        $display("FAIL rnd_addr[%0d]: got %0d want %0d", c,
          sram_address, exp_addr);
      end
      if (exp_ctl[1:0] != 2'b00) begin
        got_data = exp_ctl[1] ? a_readdata : b_readdata;
        n_tests++;
        if (got_data !== m_pend_data) begin
          n_fail++;
          $display("FAIL rnd_data[%0d]: got %h want %h", c,
            got_data, m_pend_data);
        end
      end
      if (!reset_n)
        m_reset();
      else if (g == 1)
        m_commit(1, a_read, a_address, a_write, a_writedata, a_byteenable);
      else if (g == 2)
        m_commit(2, b_read, b_address, b_write, b_writedata, b_byteenable);
      else
        m_commit(0, 0, '0, 0, '0, '0);
      @(posedge clk); #1;
    end
    reset_n = 1;
    idle();
  endtask

  initial begin
    idle();
    preload = 1;
    reset_n = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = init_word(i);
    m_reset();
    @(posedge clk); #1;
    preload = 0;
    test_reset();
    test_write_read();
    test_hold();
    test_saturate();
    test_tie();
    test_byteenable();
    test_reset_midburst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one 512-bit, 16-word on-chip SRAM port between two Avalon-MM requesters: A (HPS-side bridge) and B (hardware accelerator).
- Round-robin arbitration with bounded burst hold, so neither requester can starve the other.
- Drives the SRAM port's address, chipselect, write, byteenable, writedata and clken.
- The SRAM registers the address and returns data unregistered, so read data is valid one clock after the address is accepted; this block generates readdatavalid and routes the data to its owner.

Parameters:
- ADDR_W, 4: word-address width (16 words).
- DATA_W, 512: data width.
- BE_W, 64: byteenable width (DATA_W/8).
- MAX_HOLD, 4: maximum consecutive grants to one requester while the other is requesting; legal range 1..15.

Ports:
- clk  in  1  single clock for the block and the SRAM port.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- a_address  in  ADDR_W  requester A word address.
- a_read  in  1  requester A read request.
- a_write  in  1  requester A write request.
- a_writedata  in  DATA_W  requester A write data.
- a_byteenable  in  BE_W  requester A byte lanes.
- a_waitrequest  out  1  high = A's request not accepted this cycle.
- a_readdata  out  DATA_W  read data returned to A.
- a_readdatavalid  out  1  A's read data valid.
- b_address, b_read, b_write, b_writedata, b_byteenable, b_waitrequest, b_readdata, b_readdatavalid: same as the A ports, for requester B.
- sram_address  out  ADDR_W  to the SRAM port.
- sram_chipselect  out  1  to the SRAM port.
- sram_write  out  1  to the SRAM port.
- sram_writedata  out  DATA_W  to the SRAM port.
- sram_byteenable  out  BE_W  to the SRAM port.
- sram_clken  out  1  to the SRAM port; constant 1 out of reset.
- sram_readdata  in  DATA_W  from the SRAM port.

Behaviour:
- Request definition: req_X = X_read | X_write. Simultaneous read and write from one requester is illegal; write takes priority and the read is ignored.
- Acceptance: a transfer is accepted in the cycle where req_X=1 and X_waitrequest=0.
  - Grant is combinational from the current state and the current requests.
  - The SRAM outputs are a combinational mux of the granted requester's signals.
  - sram_chipselect = grant valid.
  - With no grant: sram_chipselect=0, sram_write=0, sram_address=0, sram_byteenable=0.
- State registers:
  - owner: NONE/A/B.
  - hold_cnt: 4 bits.
  - rr_last: last requester granted.
  - rd_pend, rd_owner: a single-stage return pipeline.
- Grant rule, evaluated each cycle:
  - owner X requesting, and (hold_cnt < MAX_HOLD or other not requesting) -> grant X.
  - otherwise, other requesting -> grant other.
  - otherwise, owner NONE and both requesting -> grant the requester != rr_last.
  - otherwise -> grant the sole requester, if any.
- Waitrequest: X_waitrequest = req_X & ~grant_X. It is 0 when X is idle.
- Register update on each grant:
  - owner <- grantee; rr_last <- grantee.
  - hold_cnt <- hold_cnt+1 if the grantee equals the previous owner, else 1.
  - hold_cnt saturates at 15.
- No grant in a cycle: owner <- NONE, hold_cnt <- 0; rr_last is kept.
- Read return:
  - An accepted read sets rd_pend=1 and rd_owner=grantee for the next cycle.
  - In that next cycle, X_readdatavalid = rd_pend & (rd_owner==X), and X_readdata = sram_readdata.
  - Fixed latency is 1 cycle. Back-to-back reads stream at 1 per cycle.
- Writes:
  - Take effect on the acceptance edge; no response is generated.
  - A read of the same address in the next cycle returns the new data.
- Byteenable of all zeros: passed through unchanged; the SRAM is left unchanged; not an error.
- Readdata when not valid: X_readdata is don't-care, but is driven from sram_readdata, never X.
- Reset (reset_n=0 at a clock edge), including mid-burst:
  - owner=NONE, hold_cnt=0, rr_last=B (so A wins the first tie), rd_pend=0.
  - A read accepted in the cycle before reset yields no readdatavalid after reset.
  - During reset, both waitrequests are 1 and sram_chipselect=0.
  - sram_clken=1 from the first post-reset cycle.

Decomposition:
- Package sram_arb_pkg holds:
  - typedef owner_t {OWN_NONE, OWN_A, OWN_B};
  - localparams ADDR_W/DATA_W/BE_W defaults;
  - MAX_HOLD_LIMIT=15.
- One natural sub-module: sram_arb_rr_core. It takes req_a, req_b and the state, and produces grant_a, grant_b and the next state.
- The datapath muxing and the read-return pipeline stay in the top level.

Test Plan:
1. Reset then A write addr 3, data 0xA5 pattern, be all-ones; next cycle A read addr 3 -> a_waitrequest=0 both cycles; a_readdatavalid=1 exactly one cycle after read acceptance; a_readdata=pattern; b_readdatavalid stays 0.
2. A and B both read continuously from cycle 0, MAX_HOLD=4 -> grant sequence A,A,A,A,B,B,B,B,A...; each requester sees waitrequest=1 on its 4 stalled cycles; readdatavalid owner matches the grantee of the previous cycle.
3. A requests alone for 10 cycles, B idle -> A granted every cycle; hold_cnt saturates with no switch; B raises request at cycle 10 -> B granted at cycle 10.
4. Single-cycle simultaneous A read and B read after reset -> A granted first (rr_last=B); B granted next cycle; both get readdatavalid one cycle after their own acceptance.
5. B write with byteenable=0x...0001 to addr 15 over known data -> only byte 0 changes on readback; address 15 to 0 then wraps with no aliasing.
6. A read accepted; reset_n=0 on the following edge -> no a_readdatavalid after reset; both waitrequests are 1 during reset; first post-reset tie goes to A.
